// File: rtl/rv32i_types.sv
// Shared RV32I types for the fetch stage: opcode encodings, fetch FSM states and the
// IF/ID pipeline record.
package rv32i_types;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OpLoad    = 7'b0000011,
    OpMiscMem = 7'b0001111,
    OpImm     = 7'b0010011,
    OpAuipc   = 7'b0010111,
    OpStore   = 7'b0100011,
    OpReg     = 7'b0110011,
    OpLui     = 7'b0110111,
    OpBranch  = 7'b1100011,
    OpJalr    = 7'b1100111,
    OpJal     = 7'b1101111,
    OpSystem  = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_address,
    output imem_read,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_address,
    input  imem_read,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load and clear; reset behaves exactly like clear.
module if_id_reg
  import rv32i_types::*;
#(
  parameter logic [31:0] CLEAR_IR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '{valid: 1'b0, pc: 32'h0, ir: CLEAR_IR};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage plus IF/ID register: owns the PC, issues imem reads, handles stall/redirect.
// Optional FETCH_PERF_EN adds fetched-instruction and memory-wait counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [31:0]              redirect_pc,
  fetch_stage_if.master            imem,
  output logic                     if_id_valid,
  output logic [31:0]              if_id_pc,
  output logic [31:0]              if_id_ir,
  output rv32i_types::rv32i_opcode opcode,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [4:0]               rd,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall_cycles
`endif
);

  rv32i_types::fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic        ifid_load, ifid_clear;
  rv32i_types::if_id_t ifid_d, ifid_q;

  assign imem.imem_address = pc_q;
  assign imem.imem_read    = !rst && (state_q != rv32i_types::S_HOLD);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    hold_pc_d  = hold_pc_q;
    hold_ir_d  = hold_ir_q;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    ifid_d     = '{valid: 1'b1, pc: pc_q, ir: imem.imem_rdata};

    case (state_q)
      rv32i_types::S_REQ: begin
        if (flush) begin
          ifid_clear = 1'b1;
          if (imem.imem_resp) begin
            pc_d = redirect_pc;
          end else begin
            // The read cannot be abandoned mid-flight; park the target until it completes.
            target_d = redirect_pc;
            state_d  = rv32i_types::S_DRAIN;
          end
        end else if (imem.imem_resp && stall) begin
          hold_pc_d = pc_q;
          hold_ir_d = imem.imem_rdata;
          state_d   = rv32i_types::S_HOLD;
        end else if (imem.imem_resp) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
        end else if (!stall) begin
          ifid_clear = 1'b1;
        end
      end
      rv32i_types::S_HOLD: begin
        if (flush) begin
          ifid_clear = 1'b1;
          pc_d       = redirect_pc;
          state_d    = rv32i_types::S_REQ;
        end else if (!stall) begin
          ifid_load = 1'b1;
          ifid_d    = '{valid: 1'b1, pc: hold_pc_q, ir: hold_ir_q};
          pc_d      = pc_q + 32'd4;
          state_d   = rv32i_types::S_REQ;
        end
      end
      rv32i_types::S_DRAIN: begin
        ifid_clear = 1'b1;
        if (flush) begin
          target_d = redirect_pc;
        end
        if (imem.imem_resp) begin
          pc_d    = flush ? redirect_pc : target_q;
          state_d = rv32i_types::S_REQ;
        end
      end
      default: state_d = rv32i_types::S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= rv32i_types::S_REQ;
      pc_q      <= RESET_PC;
      target_q  <= 32'h0;
      hold_pc_q <= 32'h0;
      hold_ir_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      hold_pc_q <= hold_pc_d;
      hold_ir_q <= hold_ir_d;
    end
  end

  if_id_reg #(
    .CLEAR_IR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .clear (ifid_clear),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign if_id_valid = ifid_q.valid;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_ir    = ifid_q.ir;
  assign opcode      = rv32i_types::rv32i_opcode'(ifid_q.ir[6:0]);
  assign rd          = ifid_q.ir[11:7];
  assign funct3      = ifid_q.ir[14:12];
  assign rs1         = ifid_q.ir[19:15];
  assign rs2         = ifid_q.ir[24:20];
  assign funct7      = ifid_q.ir[31:25];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched      <= 32'h0;
      perf_stall_cycles <= 32'h0;
    end else begin
      if (ifid_load && ifid_d.valid) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (imem.imem_read && !imem.imem_resp) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/flush/latency traffic
// checked against a behavioural pipeline model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [31:0] redirect_pc;
  logic if_id_valid;
  logic [31:0] if_id_pc, if_id_ir;
  rv32i_types::rv32i_opcode opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
`endif

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_ir    (if_id_ir),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Memory side: per-request latency (wait cycles before the response cycle).
  int lat = 0;
  int waited = 0;
  int fixed_lat = 0;
  int lat_q[$];

  // Behavioural model of the pipeline's visible state.
  logic [31:0] m_pc, m_target, m_hold_pc, m_hold_ir, m_ifpc, m_ir;
  logic        m_held, m_drain, m_valid;
  int unsigned m_fetched, m_waits;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  function automatic int pick_lat();
    if (lat_q.size() > 0) return lat_q.pop_front();
    if (fixed_lat >= 0) return fixed_lat;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0;
    m_ifpc  = 32'h0;
    m_ir    = NOP;
  endtask

  task automatic model_deliver(input logic [31:0] pc, input logic [31:0] word);
    m_valid = 1'b1;
    m_ifpc  = pc;
    m_ir    = word;
    m_fetched++;
  endtask

  task automatic model_update(input logic rdv, input logic resp, input logic [31:0] word);
    if (rst) begin
      m_pc = RST_PC; m_held = 1'b0; m_drain = 1'b0; m_target = 32'h0;
      m_fetched = 0; m_waits = 0;
      model_bubble();
      return;
    end
    if (rdv && !resp) m_waits++;
    if (m_held) begin
      if (flush) begin
        m_held = 1'b0; m_pc = redirect_pc; model_bubble();
      end else if (!stall) begin
        model_deliver(m_hold_pc, m_hold_ir); m_held = 1'b0; m_pc = m_pc + 32'd4;
      end
    end else if (m_drain) begin
      if (flush) m_target = redirect_pc;
      if (resp) begin
        m_pc = m_target; m_drain = 1'b0;
      end
    end else if (flush) begin
      model_bubble();
      if (resp) m_pc = redirect_pc;
      else begin
        m_target = redirect_pc; m_drain = 1'b1;
      end
    end else if (resp && stall) begin
      m_held = 1'b1; m_hold_pc = m_pc; m_hold_ir = word;
    end else if (resp) begin
      model_deliver(m_pc, word); m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      model_bubble();
    end
  endtask

  // One clock: memory answers the current request, DUT and model advance together.
  task automatic step();
    logic rdv;
    logic [31:0] a;
    #1;
    rdv = imem.imem_read;
    a   = imem.imem_address;
    if (rdv && waited >= lat) begin
      imem.imem_resp  = 1'b1;
      imem.imem_rdata = mem_word(a);
    end else begin
      imem.imem_resp  = 1'b0;
      imem.imem_rdata = $urandom;
    end
    @(posedge clk);
    model_update(rdv, imem.imem_resp, imem.imem_rdata);
    if (rst) begin
      waited = 0; lat = pick_lat();
    end else if (rdv) begin
      if (imem.imem_resp) begin
        waited = 0; lat = pick_lat();
      end else waited++;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    n_checks++;
    if (imem.imem_read !== 1'b0) $display("FAIL reset_read: got %0b want 0", imem.imem_read);
    else n_pass++;
    n_checks++;
    if ({if_id_valid, if_id_pc, if_id_ir} !== {1'b0, 32'h0, NOP})
      $display("FAIL reset_ifid: got %0b/%h/%h want 0/0/%h", if_id_valid, if_id_pc, if_id_ir, NOP);
    else n_pass++;
    n_checks++;
    if (imem.imem_address !== RST_PC)
      $display("FAIL reset_pc: got %h want %h", imem.imem_address, RST_PC);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] want;
    fixed_lat = 0;
    reset_dut();
    #1;
    n_checks++;
    if ({imem.imem_read, imem.imem_address} !== {1'b1, RST_PC})
      $display("FAIL zw_first_req: got %0b/%h want 1/%h", imem.imem_read, imem.imem_address, RST_PC);
    else n_pass++;
    step();
    want = RST_PC + 32'd4;
    n_checks++;
    if (imem.imem_address !== want)
      $display("FAIL zw_addr1: got %h want %h", imem.imem_address, want);
    else n_pass++;
    n_checks++;
    if ({if_id_valid, if_id_pc, if_id_ir} !== {1'b1, RST_PC, 32'h0050_0093})
      $display("FAIL zw_ifid: got %0b/%h/%h want 1/%h/00500093",
               if_id_valid, if_id_pc, if_id_ir, RST_PC);
    else n_pass++;
    n_checks++;
    if ({7'(opcode), rd, rs1, funct3} !== {7'h13, 5'd1, 5'd0, 3'd0})
      $display("FAIL zw_fields: got op=%h rd=%0d rs1=%0d f3=%0d want 13/1/0/0",
               opcode, rd, rs1, funct3);
    else n_pass++;
    step();
    want = RST_PC + 32'd8;
    n_checks++;
    if ({imem.imem_address, if_id_pc} !== {want, RST_PC + 32'd4})
      $display("FAIL zw_addr2: got %h/%h want %h/%h", imem.imem_address, if_id_pc, want,
               RST_PC + 32'd4);
    else n_pass++;
  endtask

  task automatic test_latency();
    fixed_lat = 2;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({imem.imem_read, imem.imem_address, if_id_valid, if_id_ir} !== {1'b1, RST_PC, 1'b0, NOP})
        $display("FAIL lat_wait%0d: got rd=%0b a=%h v=%0b ir=%h want 1/%h/0/%h", i,
                 imem.imem_read, imem.imem_address, if_id_valid, if_id_ir, RST_PC, NOP);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({if_id_valid, if_id_pc} !== {1'b1, RST_PC})
      $display("FAIL lat_deliver: got %0b/%h want 1/%h", if_id_valid, if_id_pc, RST_PC);
    else n_pass++;
  endtask

  task automatic test_stall_hold();
    fixed_lat = 0;
    reset_dut();
    step();
    stall = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({imem.imem_read, if_id_valid, if_id_pc, if_id_ir} !== {1'b0, 1'b1, RST_PC, 32'h0050_0093})
        $display("FAIL hold%0d: got rd=%0b v=%0b pc=%h ir=%h want 0/1/%h/00500093", i,
                 imem.imem_read, if_id_valid, if_id_pc, if_id_ir, RST_PC);
      else n_pass++;
      if (i == 0) step();
    end
    stall = 1'b0;
    step();
    n_checks++;
    if ({if_id_valid, if_id_pc, if_id_ir} !== {1'b1, RST_PC + 32'd4, mem_word(RST_PC + 32'd4)})
      $display("FAIL hold_release: got %0b/%h/%h want 1/%h/%h", if_id_valid, if_id_pc, if_id_ir,
               RST_PC + 32'd4, mem_word(RST_PC + 32'd4));
    else n_pass++;
    n_checks++;
    if ({imem.imem_read, imem.imem_address} !== {1'b1, RST_PC + 32'd8})
      $display("FAIL hold_next_addr: got %0b/%h want 1/%h", imem.imem_read, imem.imem_address,
               RST_PC + 32'd8);
    else n_pass++;
  endtask

  task automatic test_flush_drain();
    fixed_lat = 3;
    reset_dut();
    step();
    flush = 1'b1; redirect_pc = 32'h4000_0100;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({imem.imem_read, imem.imem_address, if_id_valid} !== {1'b1, RST_PC, 1'b0})
        $display("FAIL drain_hold%0d: got %0b/%h/%0b want 1/%h/0", i, imem.imem_read,
                 imem.imem_address, if_id_valid, RST_PC);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({imem.imem_read, imem.imem_address, if_id_valid} !== {1'b1, 32'h4000_0100, 1'b0})
      $display("FAIL drain_redirect: got %0b/%h/%0b want 1/40000100/0", imem.imem_read,
               imem.imem_address, if_id_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if ({if_id_valid, if_id_pc} !== {1'b1, 32'h4000_0100})
      $display("FAIL drain_target_fetch: got %0b/%h want 1/40000100", if_id_valid, if_id_pc);
    else n_pass++;
  endtask

  task automatic test_flush_stall_hold();
    fixed_lat = 0;
    reset_dut();
    step();
    stall = 1'b1;
    step();
    flush = 1'b1; redirect_pc = 32'h4000_0200;
    step();
    flush = 1'b0; stall = 1'b0;
    n_checks++;
    if ({imem.imem_read, imem.imem_address, if_id_valid} !== {1'b1, 32'h4000_0200, 1'b0})
      $display("FAIL hold_flush: got %0b/%h/%0b want 1/40000200/0", imem.imem_read,
               imem.imem_address, if_id_valid);
    else n_pass++;
    step();
    n_checks++;
    if ({if_id_valid, if_id_pc} !== {1'b1, 32'h4000_0200})
      $display("FAIL hold_flush_next: got %0b/%h want 1/40000200", if_id_valid, if_id_pc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    fixed_lat = 3;
    reset_dut();
    step();
    flush = 1'b1; redirect_pc = 32'h4000_0300;
    step();
    flush = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({imem.imem_read, imem.imem_address, if_id_valid} !== {1'b1, RST_PC, 1'b0})
      $display("FAIL rst_drain: got %0b/%h/%0b want 1/%h/0", imem.imem_read, imem.imem_address,
               if_id_valid, RST_PC);
    else n_pass++;
    lat = 2;
    lat_q = '{1, 0, 3, 0};
    for (int i = 0; i < 11; i++) step();
    n_checks++;
    if ({if_id_valid, if_id_pc} !== {1'b1, RST_PC + 32'h10})
      $display("FAIL perf_seq_pc: got %0b/%h want 1/%h", if_id_valid, if_id_pc, RST_PC + 32'h10);
    else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++;
    if ({perf_fetched, perf_stall_cycles} !== {32'd5, 32'd6})
      $display("FAIL perf_counts: got %0d/%0d want 5/6", perf_fetched, perf_stall_cycles);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    fixed_lat = -1;
    lat_q.delete();
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      #1;
      n_checks++;
      if ({imem.imem_read, imem.imem_address} !== {!rst && !m_held, m_pc}) begin
        errs++;
        if (errs < 10)
          $display("FAIL rnd_req@%0d: got %0b/%h want %0b/%h", i, imem.imem_read,
                   imem.imem_address, !rst && !m_held, m_pc);
      end else n_pass++;
      n_checks++;
      if ({if_id_valid, if_id_ir} !== {m_valid, m_ir} || (m_valid && if_id_pc !== m_ifpc)) begin
        errs++;
        if (errs < 10)
          $display("FAIL rnd_ifid@%0d: got %0b/%h/%h want %0b/%h/%h", i, if_id_valid, if_id_pc,
                   if_id_ir, m_valid, m_ifpc, m_ir);
      end else n_pass++;
      n_checks++;
      if ({funct7, rs2, rs1, funct3, rd, 7'(opcode)} !== m_ir) begin
        errs++;
        if (errs < 10)
          $display("FAIL rnd_fields@%0d: got %h want %h", i,
                   {funct7, rs2, rs1, funct3, rd, 7'(opcode)}, m_ir);
      end else n_pass++;
      step();
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if ({perf_fetched, perf_stall_cycles} !== {m_fetched, m_waits})
      $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_fetched, perf_stall_cycles,
               m_fetched, m_waits);
    else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    imem.imem_resp = 1'b0; imem.imem_rdata = 32'h0;
    m_pc = RST_PC; m_target = 32'h0; m_hold_pc = 32'h0; m_hold_ir = 32'h0;
    m_held = 1'b0; m_drain = 1'b0; m_fetched = 0; m_waits = 0;
    model_bubble();
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_flush_drain();
    test_flush_stall_hold();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the pipelined RV32I core.
- Owns the PC and drives the instruction-memory request, which is held stable until the response arrives.
- Latches each fetched word with its PC and splits the instruction into opcode/funct/register fields for the downstream decoder.
- Honours the hazard-unit stall and branch/jump redirects, including a redirect that arrives while an imem request is outstanding.

Parameters:
- RESET_PC, 32'h4000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding presented on if_id_ir whenever if_id_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold IF/ID contents.
- flush  in  1  redirect request from EX (taken branch, jal, jalr).
- redirect_pc  in  32  redirect target; valid when flush=1.
- imem_address  out  32  fetch address.
- imem_read  out  1  fetch request.
- imem_rdata  in  32  fetched word.
- imem_resp  in  1  one-cycle completion of the outstanding read.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_ir  out  32  IF/ID instruction word.
- opcode  out  7  if_id_ir[6:0] as rv32i_opcode.
- funct3  out  3  if_id_ir[14:12].
- funct7  out  7  if_id_ir[31:25].
- rd  out  5  if_id_ir[11:7].
- rs1  out  5  if_id_ir[19:15].
- rs2  out  5  if_id_ir[24:20].

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high on rst.
  - In the reset cycle: pc=RESET_PC, state=S_REQ, if_id_valid=0, if_id_pc=0, if_id_ir=NOP_INSTR, hold buffer empty, pending target=0.
  - imem_read=0 while rst=1; imem_read=1 from the first cycle after reset.
- Memory protocol:
  - imem_address=pc is registered and stable while imem_read=1.
  - imem_read stays high until imem_resp; the address never changes mid-request.
  - Zero-wait responses are legal: imem_resp may assert in the same cycle as the request.
  - The field outputs are purely combinational from if_id_ir.
- FSM states: S_REQ, S_HOLD, S_DRAIN.
- S_REQ (imem_read=1):
  - resp, no stall, no flush: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; stay in S_REQ. Next request is issued the following cycle, so throughput is 1 instruction/cycle on 0-wait memory.
  - resp with stall, no flush: word and pc go to the hold buffer; IF/ID unchanged; go to S_HOLD.
  - no resp, no flush, no stall: if_id_valid <= 0 (bubble); if_id_ir <= NOP_INSTR.
  - no resp, stall: IF/ID unchanged.
  - flush with resp: discard the word; pc <= redirect_pc; if_id_valid <= 0; stay in S_REQ.
  - flush without resp: target <= redirect_pc; if_id_valid <= 0; go to S_DRAIN.
- S_HOLD (imem_read=0):
  - stall high: everything held.
  - stall low: IF/ID <= hold buffer; pc <= pc+4; go to S_REQ.
  - flush: drop the hold buffer; pc <= redirect_pc; if_id_valid <= 0; go to S_REQ.
- S_DRAIN (imem_read=1, old address):
  - wait for resp, then discard it; pc <= target; go to S_REQ.
  - a new flush while draining overwrites target.
  - flush in the same cycle as resp: the new redirect_pc wins.
  - if_id_valid stays 0 throughout.
- Priority: rst > flush > stall.
- pc+4 wraps modulo 2^32 silently.
- No alignment check on redirect_pc; the upstream ALU path already clears bit 0 for jalr.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetched[31:0] and perf_stall_cycles[31:0].
  - perf_fetched increments on every instruction written into IF/ID with valid=1.
  - perf_stall_cycles increments on every cycle where imem_read=1 and imem_resp=0.
  - Both counters clear on rst and wrap at 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Add to rv32i_types:
  - fetch_state_t enum {S_REQ, S_HOLD, S_DRAIN}.
  - if_id_t struct {valid, pc, ir}.
  - NOP_INSTR localparam mirror.
- One sub-module, if_id_reg:
  - load/clear-controlled register of if_id_t.
  - clear forces {0, 0, NOP_INSTR}.
  - reset behaves as clear.
- FSM, PC, and hold buffer stay in fetch_stage.

Test Plan:
- Reset, then 0-wait memory returning sequential words: imem_address 0x40000000, 0x40000004, 0x40000008 on consecutive cycles; if_id_valid=1 from the 2nd post-reset cycle; ir 0x00500093 gives opcode=0x13, rd=1, rs1=0, funct3=0.
- Memory with 3-cycle latency: address holds 0x40000000 for 3 cycles with imem_read=1; if_id_valid=0 and if_id_ir=0x00000013 during the wait.
- stall=1 as resp arrives: state S_HOLD, imem_read=0, IF/ID unchanged; stall drops, then IF/ID takes the held word and the next address is pc+4.
- flush with redirect_pc=0x40000100 two cycles into a 4-cycle request: old address held until resp; the returned word never reaches IF/ID; next request is to 0x40000100.
- flush and stall together in S_HOLD: redirect wins; hold buffer dropped; next address is redirect_pc; if_id_valid=0.
- rst asserted mid-S_DRAIN: next cycle state=S_REQ, pc=0x40000000, if_id_valid=0. With FETCH_PERF_EN, 5 fetches plus 6 wait cycles give perf_fetched=5 and perf_stall_cycles=6.
